// File: rtl/charmquark1984_pkg.sv
// Shared types and constants for the wash cycle sequencer: phase states,
// seven-segment glyphs and actuator bit positions.
package charmquark1984_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WASH,
    ST_DRAIN,
    ST_SPIN,
    ST_DONE
  } state_t;

  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_DONE = 7'b1011110;

  localparam int ACT_FILL  = 0;
  localparam int ACT_WASH  = 1;
  localparam int ACT_DRAIN = 2;
  localparam int ACT_SPIN  = 3;

  // Segment order is {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every MAX_COUNT enabled cycles.
module tick_prescaler #(
  parameter int MAX_COUNT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_COUNT - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Tick-driven FILL/WASH/DRAIN/SPIN sequencer with pause, abort and a
// seven-segment countdown of ticks left in the current phase.
module wash_cycle_sequencer
  import charmquark1984_pkg::*;
#(
  parameter int MAX_COUNT = 10,
  parameter int T_FILL    = 3,
  parameter int T_WASH    = 5,
  parameter int T_DRAIN   = 2,
  parameter int T_SPIN    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic [3:0] actuators,
  output logic [6:0] segments,
  output logic       busy,
  output logic       done
);

  state_t     state, state_n;
  logic [3:0] remaining, remaining_n;
  logic       paused, paused_n;
  logic       start_q, pause_q;
  logic       start_edge, pause_edge;
  logic       run, hold, tick;

  assign start_edge = start & ~start_q;
  assign pause_edge = pause & ~pause_q;
  assign run  = (state == ST_FILL) || (state == ST_WASH) ||
                (state == ST_DRAIN) || (state == ST_SPIN);
  // Pause status as it will be after this cycle's edge: a pausing edge
  // freezes the prescaler on the spot, so a coincident tick is held back.
  assign hold = paused ^ pause_edge;

  tick_prescaler #(.MAX_COUNT(MAX_COUNT)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (run & ~hold),
    .clr  (state_n != state),
    .tick (tick)
  );

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    paused_n    = paused;
    if (state != ST_IDLE && abort) begin
      state_n     = ST_IDLE;
      remaining_n = 4'd0;
      paused_n    = 1'b0;
    end else if (run) begin
      if (pause_edge) paused_n = ~paused;
      if (!hold && tick) begin
        if (remaining > 4'd1) begin
          remaining_n = remaining - 4'd1;
        end else begin
          case (state)
            ST_FILL:  begin state_n = ST_WASH;  remaining_n = 4'(T_WASH);  end
            ST_WASH:  begin state_n = ST_DRAIN; remaining_n = 4'(T_DRAIN); end
            ST_DRAIN: begin state_n = ST_SPIN;  remaining_n = 4'(T_SPIN);  end
            default:  begin state_n = ST_DONE;  remaining_n = 4'd0;        end
          endcase
        end
      end
    end else if (start_edge) begin
      state_n     = ST_FILL;
      remaining_n = 4'(T_FILL);
    end
  end

  // Outputs are derived from the next-state values so they line up with
  // the state register one cycle after the triggering event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= 4'd0;
      paused    <= 1'b0;
      start_q   <= 1'b1;
      pause_q   <= 1'b1;
      actuators <= 4'b0000;
      segments  <= SEG_DASH;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      paused    <= paused_n;
      start_q   <= start;
      pause_q   <= pause;
      actuators <= 4'b0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      case (state_n)
        ST_IDLE: segments <= SEG_DASH;
        ST_DONE: begin
          segments <= SEG_DONE;
          done     <= 1'b1;
        end
        default: begin
          segments <= seg_digit(remaining_n);
          busy     <= 1'b1;
        end
      endcase
      if (!paused_n) begin
        case (state_n)
          ST_FILL:  actuators[ACT_FILL]  <= 1'b1;
          ST_WASH:  actuators[ACT_WASH]  <= 1'b1;
          ST_DRAIN: actuators[ACT_DRAIN] <= 1'b1;
          ST_SPIN:  actuators[ACT_SPIN]  <= 1'b1;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed bench for wash_cycle_sequencer: default instance plus a
// MAX_COUNT=1 / all-phases-one-tick instance for the fast boundary case.
module tb_wash_cycle_sequencer;

  localparam logic [6:0] S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F, S4 = 7'h66, S5 = 7'h6D;
  localparam logic [6:0] SDASH = 7'h40, SDONE = 7'h5E;

  logic clk = 1'b0;
  logic rst, start, pause, abort, start_b;
  logic [3:0] act_a, act_b;
  logic [6:0] seg_a, seg_b;
  logic busy_a, done_a, busy_b, done_b;
  logic [12:0] obs_a, obs_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  assign obs_a = {busy_a, done_a, act_a, seg_a};
  assign obs_b = {busy_b, done_b, act_b, seg_b};

  wash_cycle_sequencer dut_a (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .actuators(act_a), .segments(seg_a), .busy(busy_a), .done(done_a)
  );

  wash_cycle_sequencer #(
    .MAX_COUNT(1), .T_FILL(1), .T_WASH(1), .T_DRAIN(1), .T_SPIN(1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pause(1'b0), .abort(1'b0),
    .actuators(act_b), .segments(seg_b), .busy(busy_b), .done(done_b)
  );

  // Advance n clock edges and land 1 time unit after the last one.
  task automatic adv(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
    cyc += n;
  endtask

  task automatic go_idle();
    abort = 1'b1;
    adv(1);
    abort = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    e = {1'b0, 1'b0, 4'b0000, SDASH};
    rst = 1'b1; start = 1'b1; start_b = 1'b1; pause = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (obs_a !== e) begin bad++; $display("[TB] FAIL reset_a: got %h expected %h", obs_a, e); end
    total++;
    if (obs_b !== e) begin bad++; $display("[TB] FAIL reset_b: got %h expected %h", obs_b, e); end
    adv(3);
    total++;
    if (obs_a !== e) begin bad++; $display("[TB] FAIL reset_held_start_a: got %h expected %h", obs_a, e); end
    total++;
    if (obs_b !== e) begin bad++; $display("[TB] FAIL reset_held_start_b: got %h expected %h", obs_b, e); end
    start = 1'b0; start_b = 1'b0;
    adv(1);
  endtask

  task automatic test_full_run();
    int          ct[9];
    logic [12:0] ex[9];
    ct = '{1, 11, 30, 31, 80, 81, 101, 140, 141};
    ex = '{{2'b10, 4'b0001, S3}, {2'b10, 4'b0001, S2}, {2'b10, 4'b0001, S1},
           {2'b10, 4'b0010, S5}, {2'b10, 4'b0010, S1}, {2'b10, 4'b0100, S2},
           {2'b10, 4'b1000, S4}, {2'b10, 4'b1000, S1}, {2'b01, 4'b0000, SDONE}};
    start = 1'b1; cyc = 0;
    adv(1);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      adv(ct[i] - cyc);
      total++;
      if (obs_a !== ex[i]) begin
        bad++;
        $display("[TB] FAIL full_run c%0d: got %h expected %h", ct[i], obs_a, ex[i]);
      end
    end
  endtask

  task automatic test_pause();
    logic [12:0] e;
    go_idle();
    start = 1'b1; cyc = 0;
    adv(1);
    start = 1'b0;
    adv(40 - cyc);
    pause = 1'b1;
    adv(1);
    pause = 1'b0;
    e = {2'b10, 4'b0000, S5};
    total++;
    if (obs_a !== e) begin bad++; $display("[TB] FAIL pause_c41: got %h expected %h", obs_a, e); end
    adv(60 - cyc);
    total++;
    if (obs_a !== e) begin bad++; $display("[TB] FAIL pause_c60: got %h expected %h", obs_a, e); end
    pause = 1'b1;
    adv(1);
    pause = 1'b0;
    e = {2'b10, 4'b0010, S4};
    total++;
    if (obs_a !== e) begin bad++; $display("[TB] FAIL resume_c61: got %h expected %h", obs_a, e); end
    adv(100 - cyc);
    e = {2'b10, 4'b0010, S1};
    total++;
    if (obs_a !== e) begin bad++; $display("[TB] FAIL pause_wash_c100: got %h expected %h", obs_a, e); end
    adv(1);
    e = {2'b10, 4'b0100, S2};
    total++;
    if (obs_a !== e) begin bad++; $display("[TB] FAIL pause_drain_c101: got %h expected %h", obs_a, e); end
  endtask

  task automatic test_abort();
    logic [12:0] e;
    adv(105 - cyc);
    abort = 1'b1;
    adv(1);
    abort = 1'b0;
    e = {2'b00, 4'b0000, SDASH};
    total++;
    if (obs_a !== e) begin bad++; $display("[TB] FAIL abort_drain: got %h expected %h", obs_a, e); end
    adv(2);
    total++;
    if (obs_a !== e) begin bad++; $display("[TB] FAIL abort_stays_idle: got %h expected %h", obs_a, e); end
    start = 1'b1; cyc = 0;
    adv(1);
    start = 1'b0;
    e = {2'b10, 4'b0001, S3};
    total++;
    if (obs_a !== e) begin bad++; $display("[TB] FAIL abort_restart: got %h expected %h", obs_a, e); end
  endtask

  task automatic test_simultaneous();
    logic [12:0] e;
    go_idle();
    start = 1'b1; cyc = 0;
    adv(1);
    start = 1'b0;
    adv(10 - cyc);
    pause = 1'b1;
    adv(1);
    pause = 1'b0;
    e = {2'b10, 4'b0000, S3};
    total++;
    if (obs_a !== e) begin bad++; $display("[TB] FAIL pause_on_tick: got %h expected %h", obs_a, e); end
    adv(25 - cyc);
    total++;
    if (obs_a !== e) begin bad++; $display("[TB] FAIL pause_on_tick_hold: got %h expected %h", obs_a, e); end
    adv(30 - cyc);
    pause = 1'b1; abort = 1'b1;
    adv(1);
    pause = 1'b0; abort = 1'b0;
    e = {2'b00, 4'b0000, SDASH};
    total++;
    if (obs_a !== e) begin bad++; $display("[TB] FAIL abort_with_pause: got %h expected %h", obs_a, e); end
    adv(2);
    start = 1'b1; cyc = 0;
    adv(1);
    start = 1'b0;
    e = {2'b10, 4'b0001, S3};
    total++;
    if (obs_a !== e) begin bad++; $display("[TB] FAIL unpaused_after_abort: got %h expected %h", obs_a, e); end
    adv(35 - cyc);
    start = 1'b1;
    adv(1);
    start = 1'b0;
    e = {2'b10, 4'b0010, S5};
    total++;
    if (obs_a !== e) begin bad++; $display("[TB] FAIL start_in_wash: got %h expected %h", obs_a, e); end
    adv(81 - cyc);
    e = {2'b10, 4'b0100, S2};
    total++;
    if (obs_a !== e) begin bad++; $display("[TB] FAIL start_in_wash_drain: got %h expected %h", obs_a, e); end
  endtask

  task automatic test_boundary();
    logic [12:0] ex[5];
    logic [12:0] e;
    ex = '{{2'b10, 4'b0001, S1}, {2'b10, 4'b0010, S1}, {2'b10, 4'b0100, S1},
           {2'b10, 4'b1000, S1}, {2'b01, 4'b0000, SDONE}};
    start_b = 1'b1; cyc = 0;
    adv(1);
    start_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) adv(1);
      total++;
      if (obs_b !== ex[i]) begin
        bad++;
        $display("[TB] FAIL fast_c%0d: got %h expected %h", cyc, obs_b, ex[i]);
      end
    end
    adv(1);
    e = {2'b01, 4'b0000, SDONE};
    total++;
    if (obs_b !== e) begin bad++; $display("[TB] FAIL fast_done_hold: got %h expected %h", obs_b, e); end
    start_b = 1'b1;
    adv(1);
    start_b = 1'b0;
    e = {2'b10, 4'b0001, S1};
    total++;
    if (obs_b !== e) begin bad++; $display("[TB] FAIL fast_restart: got %h expected %h", obs_b, e); end
    adv(1);
    e = {2'b10, 4'b0010, S1};
    total++;
    if (obs_b !== e) begin bad++; $display("[TB] FAIL fast_restart_wash: got %h expected %h", obs_b, e); end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_pause();
    test_abort();
    test_simultaneous();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
